// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: shared state enum, opcode constants and datapath select encodings
package control_sequencer_pkg;

   typedef enum logic [4:0] {
      S_HALTED, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
      S_ADD, S_AND, S_NOT, S_BR, S_BR_TAKEN, S_JMP, S_JSR, S_JSR_LINK,
      S_LDR1, S_LDR2, S_LDR3, S_STR1, S_STR2, S_STR3, S_PAUSE1, S_PAUSE2
   } state_t;

   localparam logic [3:0] OP_BR    = 4'b0000;
   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_JSR   = 4'b0100;
   localparam logic [3:0] OP_AND   = 4'b0101;
   localparam logic [3:0] OP_LDR   = 4'b0110;
   localparam logic [3:0] OP_STR   = 4'b0111;
   localparam logic [3:0] OP_NOT   = 4'b1001;
   localparam logic [3:0] OP_JMP   = 4'b1100;
   localparam logic [3:0] OP_PAUSE = 4'b1101;

   localparam logic [1:0] PC_INC   = 2'b00;
   localparam logic [1:0] PC_ADDER = 2'b01;
   localparam logic [1:0] PC_BUS   = 2'b10;

   localparam logic [1:0] A2_ZERO  = 2'b00;
   localparam logic [1:0] A2_OFF6  = 2'b01;
   localparam logic [1:0] A2_OFF9  = 2'b10;
   localparam logic [1:0] A2_OFF11 = 2'b11;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_AND   = 2'b01;
   localparam logic [1:0] ALU_NOT   = 2'b10;
   localparam logic [1:0] ALU_PASSA = 2'b11;

   // States that stretch a memory access over MEM_WAIT cycles
   function automatic logic is_hold(input state_t s);
      return s == S_FETCH2 || s == S_LDR2 || s == S_STR3;
   endfunction

endpackage

// File: rtl/control_sequencer.sv
// control_sequencer: Moore control FSM for a small LC-3 style datapath.
// Inputs: Clk, Reset (sync, active-high), Run, Continue, Opcode/IR_5/IR_11 from IR, BEN.
// Outputs: register load strobes, bus gates, datapath mux selects, ALUK, active-low Mem_OE/Mem_WE.
module control_sequencer
   import control_sequencer_pkg::*;
#(
   parameter int MEM_WAIT = 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Run,
   input  logic       Continue,
   input  logic [3:0] Opcode,
   input  logic       IR_5,
   input  logic       IR_11,
   input  logic       BEN,
   output logic       LD_MAR,
   output logic       LD_MDR,
   output logic       LD_IR,
   output logic       LD_BEN,
   output logic       LD_CC,
   output logic       LD_REG,
   output logic       LD_PC,
   output logic       LD_LED,
   output logic       GatePC,
   output logic       GateMDR,
   output logic       GateALU,
   output logic       GateMARMUX,
   output logic [1:0] PCMUX,
   output logic [1:0] ADDR2MUX,
   output logic       DRMUX,
   output logic       SR1MUX,
   output logic       SR2MUX,
   output logic       ADDR1MUX,
   output logic [1:0] ALUK,
   output logic       Mem_OE,
   output logic       Mem_WE
);

   localparam logic [2:0] W_LAST = 3'(MEM_WAIT - 1);

   state_t     state, next;
   logic [2:0] wait_cnt;
   logic       wait_done;

   assign wait_done = wait_cnt == W_LAST;

   // Counter only advances while a hold state repeats, so it restarts at 0 on every entry
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= S_HALTED;
         wait_cnt <= '0;
      end else begin
         state    <= next;
         wait_cnt <= (is_hold(state) && next == state) ? wait_cnt + 3'd1 : '0;
      end
   end

   always_comb begin
      next       = state;
      LD_MAR     = 1'b0;
      LD_MDR     = 1'b0;
      LD_IR      = 1'b0;
      LD_BEN     = 1'b0;
      LD_CC      = 1'b0;
      LD_REG     = 1'b0;
      LD_PC      = 1'b0;
      LD_LED     = 1'b0;
      GatePC     = 1'b0;
      GateMDR    = 1'b0;
      GateALU    = 1'b0;
      GateMARMUX = 1'b0;
      PCMUX      = PC_INC;
      ADDR2MUX   = A2_ZERO;
      DRMUX      = 1'b0;
      SR1MUX     = 1'b0;
      SR2MUX     = 1'b0;
      ADDR1MUX   = 1'b0;
      ALUK       = ALU_ADD;
      Mem_OE     = 1'b1;
      Mem_WE     = 1'b1;
      case (state)
         S_HALTED: next = Run ? S_FETCH1 : S_HALTED;
         S_FETCH1: begin
            GatePC = 1'b1;
            LD_MAR = 1'b1;
            LD_PC  = 1'b1;
            PCMUX  = PC_INC;
            next   = S_FETCH2;
         end
         S_FETCH2: begin
            Mem_OE = 1'b0;
            LD_MDR = 1'b1;
            next   = wait_done ? S_FETCH3 : S_FETCH2;
         end
         S_FETCH3: begin
            GateMDR = 1'b1;
            LD_IR   = 1'b1;
            next    = S_DECODE;
         end
         S_DECODE: begin
            LD_BEN = 1'b1;
            case (Opcode)
               OP_ADD:   next = S_ADD;
               OP_AND:   next = S_AND;
               OP_NOT:   next = S_NOT;
               OP_BR:    next = S_BR;
               OP_JMP:   next = S_JMP;
               OP_JSR:   next = S_JSR;
               OP_LDR:   next = S_LDR1;
               OP_STR:   next = S_STR1;
               OP_PAUSE: next = S_PAUSE1;
               default:  next = S_FETCH1;
            endcase
         end
         S_ADD, S_AND, S_NOT: begin
            GateALU = 1'b1;
            LD_REG  = 1'b1;
            LD_CC   = 1'b1;
            SR2MUX  = IR_5;
            ALUK    = state == S_ADD ? ALU_ADD : state == S_AND ? ALU_AND : ALU_NOT;
            next    = S_FETCH1;
         end
         S_BR: next = BEN ? S_BR_TAKEN : S_FETCH1;
         S_BR_TAKEN: begin
            ADDR1MUX = 1'b0;
            ADDR2MUX = A2_OFF9;
            PCMUX    = PC_ADDER;
            LD_PC    = 1'b1;
            next     = S_FETCH1;
         end
         S_JMP: begin
            ADDR1MUX = 1'b1;
            ADDR2MUX = A2_ZERO;
            PCMUX    = PC_ADDER;
            LD_PC    = 1'b1;
            next     = S_FETCH1;
         end
         S_JSR: begin
            GatePC = 1'b1;
            DRMUX  = 1'b1;
            LD_REG = 1'b1;
            next   = S_JSR_LINK;
         end
         S_JSR_LINK: begin
            ADDR1MUX = ~IR_11;
            ADDR2MUX = IR_11 ? A2_OFF11 : A2_ZERO;
            PCMUX    = PC_ADDER;
            LD_PC    = 1'b1;
            next     = S_FETCH1;
         end
         S_LDR1, S_STR1: begin
            ADDR1MUX   = 1'b1;
            ADDR2MUX   = A2_OFF6;
            GateMARMUX = 1'b1;
            LD_MAR     = 1'b1;
            next       = state == S_LDR1 ? S_LDR2 : S_STR2;
         end
         S_LDR2: begin
            Mem_OE = 1'b0;
            LD_MDR = 1'b1;
            next   = wait_done ? S_LDR3 : S_LDR2;
         end
         S_LDR3: begin
            GateMDR = 1'b1;
            LD_REG  = 1'b1;
            LD_CC   = 1'b1;
            next    = S_FETCH1;
         end
         S_STR2: begin
            SR1MUX  = 1'b0;
            ALUK    = ALU_PASSA;
            GateALU = 1'b1;
            LD_MDR  = 1'b1;
            next    = S_STR3;
         end
         S_STR3: begin
            Mem_WE = 1'b0;
            next   = wait_done ? S_FETCH1 : S_STR3;
         end
         S_PAUSE1: begin
            LD_LED = 1'b1;
            next   = Continue ? S_PAUSE2 : S_PAUSE1;
         end
         S_PAUSE2: next = Continue ? S_PAUSE2 : S_FETCH1;
         default:  next = S_HALTED;
      endcase
   end

endmodule
